// File: rtl/frankie_pkg.sv
// Shared encodings for the Frankie multicycle control unit: opcodes, FSM
// states, datapath select codes and the instruction classes produced by
// the opcode decoder.
package frankie_pkg;

    // Opcode field values, inst[15:12]; 4'hE is undefined
    localparam logic [3:0] OP_LI   = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LUI  = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_PUSH = 4'h6;
    localparam logic [3:0] OP_POP  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_JAL  = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_BEQZ = 4'hC;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    // FSM states, visible on the debug state output
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_OR     = 3'd2;
    localparam logic [2:0] ALU_PASS_B = 3'd3;

    // Register file destination select
    localparam logic [1:0] DST_MARY    = 2'd0;
    localparam logic [1:0] DST_SHELLEY = 2'd1;
    localparam logic [1:0] DST_RA      = 2'd2;
    localparam logic [1:0] DST_SP      = 2'd3;

    // Register file write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;
    localparam logic [1:0] WB_PC  = 2'd3;

    // Next-PC source select
    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_ALU = 2'd1;
    localparam logic [1:0] PC_RA  = 2'd2;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd1;
    localparam logic [1:0] SRCB_ONE = 2'd2;

    // Instruction classes: opcodes that sequence identically share a class
    localparam logic [3:0] CLS_IMM     = 4'd0;
    localparam logic [3:0] CLS_MOV     = 4'd1;
    localparam logic [3:0] CLS_ALU     = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STORE   = 4'd4;
    localparam logic [3:0] CLS_PUSH    = 4'd5;
    localparam logic [3:0] CLS_POP     = 4'd6;
    localparam logic [3:0] CLS_JAL     = 4'd7;
    localparam logic [3:0] CLS_JR      = 4'd8;
    localparam logic [3:0] CLS_BEQZ    = 4'd9;
    localparam logic [3:0] CLS_HALT    = 4'd10;
    localparam logic [3:0] CLS_ILLEGAL = 4'd11;

endpackage

// File: rtl/frankie_ctrl_decode.sv
// Combinational opcode-to-class decoder for the Frankie control FSM.
module frankie_ctrl_decode
    import frankie_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [3:0]          cls
);

    logic [3:0] op4;
    assign op4 = opcode[3:0];

    // Group opcodes by how the FSM has to sequence them
    always_comb begin
        cls = CLS_ILLEGAL;
        case (op4)
            OP_LI, OP_LUI:                 cls = CLS_IMM;
            OP_MOV:                        cls = CLS_MOV;
            OP_ADDI, OP_ADD, OP_SUB, OP_ORI: cls = CLS_ALU;
            OP_LW:                         cls = CLS_LOAD;
            OP_SW:                         cls = CLS_STORE;
            OP_PUSH:                       cls = CLS_PUSH;
            OP_POP:                        cls = CLS_POP;
            OP_JAL:                        cls = CLS_JAL;
            OP_JR:                         cls = CLS_JR;
            OP_BEQZ:                       cls = CLS_BEQZ;
            OP_HALT:                       cls = CLS_HALT;
            default:                       cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/frankie_control.sv
// Multicycle control FSM for the Frankie core. Sequences
// fetch/decode/execute/memory/writeback and drives every datapath strobe.
// Optional build macro FRANKIE_CTRL_STALL_EN adds the mem_ready port and
// lets FETCH and MEM wait for a slow memory.
module frankie_control
    import frankie_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
`ifdef FRANKIE_CTRL_STALL_EN
    input  logic                mem_ready,
`endif
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          wb_src,
    output logic [2:0]          state,
    output logic                halted,
    output logic                illegal
);

    logic [2:0] state_q;
    logic [2:0] next_state;
    logic       illegal_q;
    logic       set_illegal;
    logic [3:0] cls;
    logic       ready;
    logic [3:0] op4;

    logic       pc_write_c, ir_write_c, iord_c, mem_read_c, mem_write_c, reg_write_c;
    logic [1:0] pc_src_c, alu_src_b_c, reg_dst_c, wb_src_c;
    logic [2:0] alu_op_c;
    logic [1:0] alu_b_sel;
    logic [2:0] alu_sel;

`ifdef FRANKIE_CTRL_STALL_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    assign op4 = opcode[3:0];

    frankie_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    // ALU operand and operation for the register/immediate arithmetic group
    always_comb begin
        alu_b_sel = SRCB_REG;
        alu_sel   = ALU_ADD;
        case (op4)
            OP_ADDI: begin alu_b_sel = SRCB_IMM; alu_sel = ALU_ADD; end
            OP_ADD:  begin alu_b_sel = SRCB_REG; alu_sel = ALU_ADD; end
            OP_SUB:  begin alu_b_sel = SRCB_REG; alu_sel = ALU_SUB; end
            OP_ORI:  begin alu_b_sel = SRCB_IMM; alu_sel = ALU_OR;  end
            default: begin alu_b_sel = SRCB_REG; alu_sel = ALU_ADD; end
        endcase
    end

    // Next-state and raw strobe decode from current state and instruction class
    always_comb begin
        next_state  = state_q;
        set_illegal = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = PC_INC;
        ir_write_c  = 1'b0;
        iord_c      = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        alu_src_b_c = SRCB_REG;
        alu_op_c    = ALU_ADD;
        reg_write_c = 1'b0;
        reg_dst_c   = DST_MARY;
        wb_src_c    = WB_ALU;
        case (state_q)
            ST_FETCH: begin
                mem_read_c = 1'b1;
                ir_write_c = ready;
                pc_write_c = ready;
                if (ready) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (cls)
                    CLS_IMM, CLS_MOV: next_state = ST_WB;
                    CLS_HALT:         next_state = ST_HALT;
                    CLS_ILLEGAL: begin
                        set_illegal = 1'b1;
                        next_state  = ST_FETCH;
                    end
                    default:          next_state = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                next_state = ST_FETCH;
                case (cls)
                    CLS_ALU: begin
                        alu_src_b_c = alu_b_sel;
                        alu_op_c    = alu_sel;
                        next_state  = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b_c = SRCB_IMM;
                        next_state  = ST_MEM;
                    end
                    CLS_PUSH, CLS_POP: begin
                        alu_src_b_c = SRCB_ONE;
                        alu_op_c    = (cls == CLS_PUSH) ? ALU_SUB : ALU_ADD;
                        reg_write_c = 1'b1;
                        reg_dst_c   = DST_SP;
                        next_state  = ST_MEM;
                    end
                    CLS_JAL: begin
                        alu_src_b_c = SRCB_IMM;
                        pc_write_c  = 1'b1;
                        pc_src_c    = PC_ALU;
                        reg_write_c = 1'b1;
                        reg_dst_c   = DST_RA;
                        wb_src_c    = WB_PC;
                    end
                    CLS_JR: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = PC_RA;
                    end
                    CLS_BEQZ: begin
                        alu_src_b_c = SRCB_IMM;
                        pc_src_c    = PC_ALU;
                        pc_write_c  = zero;
                    end
                    default: next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                iord_c = 1'b1;
                if (cls == CLS_LOAD || cls == CLS_POP) begin
                    mem_read_c = 1'b1;
                    if (ready) next_state = ST_WB;
                end else begin
                    mem_write_c = 1'b1;
                    if (ready) next_state = ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write_c = 1'b1;
                next_state  = ST_FETCH;
                case (cls)
                    CLS_IMM: wb_src_c = WB_IMM;
                    CLS_MOV: alu_op_c = ALU_PASS_B;
                    CLS_ALU: begin
                        alu_src_b_c = alu_b_sel;
                        alu_op_c    = alu_sel;
                    end
                    CLS_LOAD, CLS_POP: wb_src_c = WB_MEM;
                    default: wb_src_c = WB_ALU;
                endcase
            end
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_FETCH;
        endcase
    end

    // State register and sticky illegal-opcode flag, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    assign pc_write  = reset & pc_write_c;
    assign pc_src    = reset ? pc_src_c : 2'd0;
    assign ir_write  = reset & ir_write_c;
    assign iord      = reset & iord_c;
    assign mem_read  = reset & mem_read_c;
    assign mem_write = reset & mem_write_c;
    assign alu_src_b = reset ? alu_src_b_c : 2'd0;
    assign alu_op    = reset ? ALUOP_W'(alu_op_c) : '0;
    assign reg_write = reset & reg_write_c;
    assign reg_dst   = reset ? reg_dst_c : 2'd0;
    assign wb_src    = reset ? wb_src_c : 2'd0;
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_frankie_control.sv
// Directed self-checking bench for frankie_control. Expected strobe values
// are written out per state by hand. Define FRANKIE_CTRL_STALL_EN to also
// exercise the memory-stall behaviour.
module tb_frankie_control;

    logic       clock;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
`ifdef FRANKIE_CTRL_STALL_EN
    logic       mem_ready;
`endif
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic [2:0] state;
    logic       halted;
    logic       illegal;

    int checkCount = 0;
    int failCount  = 0;

    frankie_control dut (
        .clock     (clock),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
`ifdef FRANKIE_CTRL_STALL_EN
        .mem_ready (mem_ready),
`endif
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .ir_write  (ir_write),
        .iord      (iord),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .state     (state),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic z);
        opcode = op;
        zero   = z;
        #1;
    endtask

    task automatic checkCycle(input string tag, input logic [2:0] st,
                              input logic pcw, input logic [1:0] pcs, input logic irw,
                              input logic io, input logic mr, input logic mw,
                              input logic [1:0] asb, input logic [2:0] aop,
                              input logic rw, input logic [1:0] rd, input logic [1:0] wb);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = {15'd0, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               alu_src_b, alu_op, reg_write, reg_dst, wb_src};
        exp = {15'd0, pcw, pcs, irw, io, mr, mw, asb, aop, rw, rd, wb};
        checkOutput({tag, ".state"}, {29'd0, state}, {29'd0, st});
        checkOutput({tag, ".strobes"}, obs, exp);
    endtask

    task automatic checkFetch(input string tag);
        checkCycle(tag, 3'd0, 1, 2'd0, 1, 0, 1, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
    endtask

    task automatic checkIdle(input string tag, input logic [2:0] st);
        checkCycle(tag, st, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
    endtask

    initial begin
        reset  = 1'b0;
        opcode = 4'h2;
        zero   = 1'b0;
`ifdef FRANKIE_CTRL_STALL_EN
        mem_ready = 1'b1;
`endif
        step();
        step();
        checkOutput("rst.illegal", {31'd0, illegal}, 32'd0);
        checkOutput("rst.halted", {31'd0, halted}, 32'd0);

        // Reset asserted while an ADD sits in EXEC
        reset = 1'b1;
        #1;
        checkFetch("rst.fetch");
        step();
        checkIdle("rst.decode", 3'd1);
        step();
        checkCycle("rst.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
        reset = 1'b0;
        #1;
        checkIdle("rst.gated", 3'd2);
        step();
        checkIdle("rst.hold1", 3'd0);
        step();
        checkIdle("rst.hold2", 3'd0);
        step();
        checkIdle("rst.hold3", 3'd0);
        reset = 1'b1;
        #1;
        checkFetch("rst.release");
        step();
        checkIdle("rst.decode2", 3'd1);
        step();
        step();
        step();

        // LI: FETCH, DECODE, WB
        applyStimulus(4'h0, 1'b0);
        checkFetch("li.fetch");
        step();
        checkIdle("li.decode", 3'd1);
        step();
        checkCycle("li.wb", 3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 2'd2);
        step();

        // ADDI: immediate operand
        applyStimulus(4'h1, 1'b0);
        checkFetch("addi.fetch");
        step();
        checkIdle("addi.decode", 3'd1);
        step();
        checkCycle("addi.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd1, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkCycle("addi.wb", 3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd1, 3'd0, 1, 2'd0, 2'd0);
        step();

        // ADD: register operand
        applyStimulus(4'h2, 1'b0);
        step();
        step();
        checkCycle("add.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkCycle("add.wb", 3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 2'd0);
        step();

        // SUB and ORI select different ALU operations
        applyStimulus(4'h3, 1'b0);
        step();
        step();
        checkCycle("sub.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd1, 0, 2'd0, 2'd0);
        step();
        step();
        applyStimulus(4'h5, 1'b0);
        step();
        step();
        checkCycle("ori.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd1, 3'd2, 0, 2'd0, 2'd0);
        step();
        step();

        // LW: five states, memory data written back
        applyStimulus(4'h8, 1'b0);
        checkFetch("lw.fetch");
        step();
        checkIdle("lw.decode", 3'd1);
        step();
        checkCycle("lw.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd1, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkCycle("lw.mem", 3'd3, 0, 2'd0, 0, 1, 1, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkCycle("lw.wb", 3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 2'd1);
        step();

        // SW: single write pulse then straight back to FETCH
        applyStimulus(4'h9, 1'b0);
        step();
        step();
        checkCycle("sw.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd1, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkCycle("sw.mem", 3'd3, 0, 2'd0, 0, 1, 0, 1, 2'd0, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkFetch("sw.next");

        // PUSH: sp decremented in EXEC, then store
        applyStimulus(4'h6, 1'b0);
        step();
        step();
        checkCycle("push.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd2, 3'd1, 1, 2'd3, 2'd0);
        step();
        checkCycle("push.mem", 3'd3, 0, 2'd0, 0, 1, 0, 1, 2'd0, 3'd0, 0, 2'd0, 2'd0);
        step();

        // POP: sp incremented in EXEC, then load and write back
        applyStimulus(4'h7, 1'b0);
        step();
        step();
        checkCycle("pop.exec", 3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd2, 3'd0, 1, 2'd3, 2'd0);
        step();
        checkCycle("pop.mem", 3'd3, 0, 2'd0, 0, 1, 1, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkCycle("pop.wb", 3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 2'd1);
        step();

        // JAL: link to ra and jump in one cycle
        applyStimulus(4'hA, 1'b0);
        step();
        step();
        checkCycle("jal.exec", 3'd2, 1, 2'd1, 0, 0, 0, 0, 2'd1, 3'd0, 1, 2'd2, 2'd3);
        step();
        checkFetch("jal.next");

        // JR: PC from ra
        applyStimulus(4'hB, 1'b0);
        step();
        step();
        checkCycle("jr.exec", 3'd2, 1, 2'd2, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
        step();

        // BEQZ taken and not taken
        applyStimulus(4'hC, 1'b1);
        step();
        step();
        checkCycle("beqz.taken", 3'd2, 1, 2'd1, 0, 0, 0, 0, 2'd1, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkFetch("beqz.taken.next");
        applyStimulus(4'hC, 1'b0);
        step();
        step();
        checkCycle("beqz.nottaken", 3'd2, 0, 2'd1, 0, 0, 0, 0, 2'd1, 3'd0, 0, 2'd0, 2'd0);
        step();
        checkFetch("beqz.nottaken.next");

        // MOV and LUI skip EXEC
        applyStimulus(4'hD, 1'b0);
        step();
        step();
        checkCycle("mov.wb", 3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd3, 1, 2'd0, 2'd0);
        step();
        applyStimulus(4'h4, 1'b0);
        step();
        step();
        checkCycle("lui.wb", 3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 2'd2);
        step();

        // Undefined opcode E behaves as a NOP and sets the sticky flag
        applyStimulus(4'hE, 1'b0);
        checkOutput("ill.before", {31'd0, illegal}, 32'd0);
        step();
        checkIdle("ill.decode", 3'd1);
        step();
        checkFetch("ill.next");
        checkOutput("ill.flag", {31'd0, illegal}, 32'd1);
        applyStimulus(4'h0, 1'b0);
        step();
        step();
        step();
        checkOutput("ill.sticky", {31'd0, illegal}, 32'd1);

        // HALT is absorbing
        applyStimulus(4'hF, 1'b0);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            checkIdle($sformatf("halt.c%0d", i), 3'd5);
            checkOutput($sformatf("halt.flag%0d", i), {31'd0, halted}, 32'd1);
            step();
        end
        reset = 1'b0;
        #1;
        step();
        reset = 1'b1;
        #1;
        checkFetch("halt.reset");
        checkOutput("halt.cleared", {31'd0, halted}, 32'd0);
        checkOutput("ill.cleared", {31'd0, illegal}, 32'd0);

`ifdef FRANKIE_CTRL_STALL_EN
        begin
            int irPulses;
            irPulses = 0;
            applyStimulus(4'h8, 1'b0);
            mem_ready = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                checkCycle($sformatf("stall.fetch%0d", i), 3'd0, 0, 2'd0, 0, 0, 1, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
                if (ir_write) irPulses++;
                step();
            end
            mem_ready = 1'b1;
            #1;
            checkFetch("stall.ready");
            if (ir_write) irPulses++;
            step();
            checkIdle("stall.decode", 3'd1);
            checkOutput("stall.irpulses", irPulses, 32'd1);
            step();
            step();
            mem_ready = 1'b0;
            #1;
            checkCycle("stall.mem0", 3'd3, 0, 2'd0, 0, 1, 1, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
            step();
            checkCycle("stall.mem1", 3'd3, 0, 2'd0, 0, 1, 1, 0, 2'd0, 3'd0, 0, 2'd0, 2'd0);
            mem_ready = 1'b1;
            #1;
            step();
            checkCycle("stall.wb", 3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 2'd1);
            step();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
